// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI initiator.
//   SPI_OP_*     opcode field values carried in cmd_data[9:8]
//   SPI_FRAME_W  width of one command frame on MOSI
//   SPI_DATA_W   width of a read reply captured from MISO
//   spi_state_t  state encoding of the spi_master FSM
package spi_pkg;

  localparam int SPI_FRAME_W = 10;
  localparam int SPI_DATA_W  = 8;

  localparam logic [1:0] SPI_OP_WR_ADDR = 2'b00;
  localparam logic [1:0] SPI_OP_WR_DATA = 2'b01;
  localparam logic [1:0] SPI_OP_RD_ADDR = 2'b10;
  localparam logic [1:0] SPI_OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_TURN_WAIT,
    ST_READ,
    ST_DONE
  } spi_state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// spi_master_shifter: parallel-load left shift register for one outgoing
// frame plus the bit counter that marks the last bit.
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset (counter only)
//   load       load load_data and clear the bit counter
//   shift      shift left by one and advance the bit counter
//   load_data  frame to be transmitted, MSB first
//   msb_nxt    value the register MSB takes after this edge, so the
//              caller can register MOSI in step with the shift
//   done       high while the last frame bit is at the MSB
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   shift,
  input  logic [SPI_FRAME_W-1:0] load_data,
  output logic                   msb_nxt,
  output logic                   done
);

  logic [SPI_FRAME_W-1:0] shreg_p0;
  logic [3:0]             bit_cnt;

  always_ff @(posedge clk) begin
    if (load)
      shreg_p0 <= load_data;
    else if (shift)
      shreg_p0 <= {shreg_p0[SPI_FRAME_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      bit_cnt <= '0;
    else if (load)
      bit_cnt <= '0;
    else if (shift && !done)
      bit_cnt <= bit_cnt + 4'd1;
  end

  always_comb begin
    msb_nxt = shreg_p0[SPI_FRAME_W-1];
    if (load)
      msb_nxt = load_data[SPI_FRAME_W-1];
    else if (shift)
      msb_nxt = shreg_p0[SPI_FRAME_W-2];
  end

  assign done = (bit_cnt == 4'(SPI_FRAME_W - 1));

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI initiator. Serialises 10-bit commands MSB first on MOSI
// under SS_n; rd-data commands are followed by a turnaround window and an
// 8-bit capture from MISO returned with a one-cycle rd_valid pulse.
// Optional feature macro: SPI_MASTER_RDSEQ_CHECK_EN rejects an rd-data
// command (err pulse, no frame) unless an rd-addr frame preceded it.
//   clk, rst_n          clock / synchronous active-low reset
//   cmd_valid/ready     command handshake, ready only in IDLE
//   cmd_data[9:0]       [9:8] opcode, [7:0] payload
//   SS_n, MOSI, MISO    SPI pins (SS_n and MOSI registered)
//   rd_valid, rd_data   read reply pulse and held reply byte
//   busy                high outside IDLE
//   err                 one-cycle pulse on a rejected command
module spi_master
  import spi_pkg::*;
#(
  parameter int TURN     = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SPI_FRAME_W-1:0] cmd_data,
  output logic                   SS_n,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic                   rd_valid,
  output logic [SPI_DATA_W-1:0]  rd_data,
  output logic                   busy,
  output logic                   err
);

  spi_state_t            state;
  logic [3:0]            wait_cnt;
  logic [1:0]            op;
  logic [SPI_DATA_W-2:0] rx_p0;
  logic                  accept;
  logic                  reject;
  logic                  sh_load;
  logic                  sh_shift;
  logic                  sh_msb_nxt;
  logic                  sh_done;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_RDSEQ_CHECK_EN
  logic rd_addr_sent;

  always_comb begin
    reject = 1'b0;
    if (accept && (cmd_data[9:8] == SPI_OP_RD_DATA) && !rd_addr_sent)
      reject = 1'b1;
  end

  // Pairing flag: an rd-addr frame arms it, a completed read disarms it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_addr_sent <= 1'b0;
    else if (state == ST_SHIFT && sh_done && op == SPI_OP_RD_ADDR)
      rd_addr_sent <= 1'b1;
    else if (state == ST_READ && wait_cnt == 4'(SPI_DATA_W - 1))
      rd_addr_sent <= 1'b0;
  end
`else
  always_comb begin
    reject = 1'b0;
  end
`endif

  assign sh_load  = accept && !reject;
  assign sh_shift = (state == ST_SHIFT);

  spi_master_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (cmd_data),
    .msb_nxt   (sh_msb_nxt),
    .done      (sh_done)
  );

  // Only the first seven samples need storing; the eighth goes straight
  // into rd_data on the closing edge.
  always_ff @(posedge clk) begin
    if (state == ST_READ)
      rx_p0 <= {rx_p0[SPI_DATA_W-3:0], MISO};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      op       <= SPI_OP_WR_ADDR;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= reject;
      case (state)
        ST_IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (reject) begin
            // Rejected command spends exactly one cycle in DONE.
            state    <= ST_DONE;
            wait_cnt <= 4'(IDLE_GAP - 1);
          end else if (accept) begin
            state    <= ST_SHIFT;
            wait_cnt <= '0;
            op       <= cmd_data[9:8];
            SS_n     <= 1'b0;
            MOSI     <= sh_msb_nxt;
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            MOSI     <= 1'b0;
            wait_cnt <= '0;
            if (op == SPI_OP_RD_DATA) begin
              state <= ST_TURN_WAIT;
            end else begin
              state <= ST_DONE;
              SS_n  <= 1'b1;
            end
          end else begin
            MOSI <= sh_msb_nxt;
          end
        end
        ST_TURN_WAIT: begin
          if (wait_cnt == 4'(TURN - 1)) begin
            state    <= ST_READ;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_READ: begin
          if (wait_cnt == 4'(SPI_DATA_W - 1)) begin
            state    <= ST_DONE;
            wait_cnt <= '0;
            SS_n     <= 1'b1;
            rd_data  <= {rx_p0, MISO};
            rd_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (wait_cnt == 4'(IDLE_GAP - 1)) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
          SS_n     <= 1'b1;
          MOSI     <= 1'b0;
        end
      endcase
    end
  end

endmodule
